// File: rtl/player_motion_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : player_motion_ctrl
// Purpose : per-frame player motion with accel/decel and bounds, latched fire
//           with cooldown, and a blinking stun state after a hit.
// Rev     : 1.0
// =============================================================================
module player_motion_ctrl #(
    parameter int INITIAL_X     = 240,
    parameter int INITIAL_Y     = 420,
    parameter int FRAC_BITS     = 6,
    parameter int ACCEL         = 32,
    parameter int DECEL         = 64,
    parameter int MAX_SPEED     = 128,
    parameter int X_MIN         = 15,
    parameter int X_MAX         = 562,
    parameter int FIRE_COOLDOWN = 8,
    parameter int STUN_FRAMES   = 60,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic                          playGame,
    input  logic                          leftArrow,
    input  logic                          rightArrow,
    input  logic                          fireKey,
    input  logic                          collision,
    input  logic [3:0]                    HitEdgeCode,
    input  logic                          playerHit,
    input  logic                          shotBusy,
    output logic signed [10:0]            topLeftX,
    output logic signed [10:0]            topLeftY,
    output logic signed [11+FRAC_BITS-1:0] speedX,
    output logic                          fireReq,
    output logic                          visible,
    output logic                          stunned
);

    localparam int PW  = 11 + FRAC_BITS;
    localparam int EW  = PW + 1;
    localparam int CW  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam int SWA = $clog2(STUN_FRAMES + 1);
    localparam int SW  = (SWA > BLINK_SHIFT) ? SWA : BLINK_SHIFT + 1;

    localparam logic signed [PW-1:0] POS_INIT = PW'(INITIAL_X * (1 << FRAC_BITS));
    localparam logic signed [EW-1:0] ACC_S    = EW'(ACCEL);
    localparam logic signed [EW-1:0] DEC_S    = EW'(DECEL);
    localparam logic signed [EW-1:0] DECN_S   = EW'(-DECEL);
    localparam logic signed [EW-1:0] MAX_S    = EW'(MAX_SPEED);
    localparam logic signed [EW-1:0] MAXN_S   = EW'(-MAX_SPEED);
    localparam logic signed [EW-1:0] XMIN_S   = EW'(X_MIN * (1 << FRAC_BITS));
    localparam logic signed [EW-1:0] XMAX_S   = EW'(X_MAX * (1 << FRAC_BITS));
    localparam logic [CW-1:0]        COOL_INIT = CW'(FIRE_COOLDOWN);
    localparam logic [SW-1:0]        STUN_INIT = SW'(STUN_FRAMES);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        STUNNED = 2'd2
    } state_t;

    state_t                 state;
    logic signed [PW-1:0]   pos_x;
    logic [CW-1:0]          cooldown;
    logic [SW-1:0]          stun_cnt;
    logic                   pending;
    logic                   block_l;
    logic                   block_r;
    logic                   fire_prev;

    logic signed [EW-1:0]   spd_cur;
    logic signed [EW-1:0]   spd_inc;
    logic signed [EW-1:0]   spd_dec;
    logic signed [EW-1:0]   spd_new;
    logic signed [EW-1:0]   pos_new;
    logic                   blk_r;
    logic                   blk_l;
    logic                   fire_rise;
    logic                   fire_ok;
    logic [CW-1:0]          cd_dec;
    logic [SW-1:0]          stun_dec;
    logic                   unused_edges;

    assign unused_edges = HitEdgeCode[0] ^ HitEdgeCode[2];
    assign topLeftX     = pos_x[PW-1 -: 11];
    assign topLeftY     = 11'(INITIAL_Y);

    // Same-clk collisions count toward this frame's blocking, since the flags clear at the frame edge.
    always_comb begin
        blk_r     = block_r | (collision & HitEdgeCode[1]);
        blk_l     = block_l | (collision & HitEdgeCode[3]);
        fire_rise = fireKey & ~fire_prev;
        cd_dec    = (cooldown == '0) ? '0 : cooldown - CW'(1);
        stun_dec  = (stun_cnt == '0) ? '0 : stun_cnt - SW'(1);
        fire_ok   = pending && (cd_dec == '0) && !shotBusy;

        spd_cur = EW'(speedX);
        spd_inc = spd_cur + ACC_S;
        spd_dec = spd_cur - ACC_S;
        if (rightArrow && !leftArrow) begin
            spd_new = blk_r ? '0 : ((spd_inc > MAX_S) ? MAX_S : spd_inc);
        end else if (leftArrow && !rightArrow) begin
            spd_new = blk_l ? '0 : ((spd_dec < MAXN_S) ? MAXN_S : spd_dec);
        end else if (spd_cur > DEC_S) begin
            spd_new = spd_cur - DEC_S;
        end else if (spd_cur < DECN_S) begin
            spd_new = spd_cur + DEC_S;
        end else begin
            spd_new = '0;
        end

        if ((!spd_new[EW-1] && (spd_new != '0) && blk_r) || (spd_new[EW-1] && blk_l)) begin
            spd_new = '0;
        end

        pos_new = EW'(pos_x) + spd_new;
        if (pos_new < XMIN_S) begin
            pos_new = XMIN_S;
            spd_new = '0;
        end else if (pos_new > XMAX_S) begin
            pos_new = XMAX_S;
            spd_new = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= HOLD;
            pos_x     <= POS_INIT;
            speedX    <= '0;
            cooldown  <= '0;
            stun_cnt  <= '0;
            pending   <= 1'b0;
            block_l   <= 1'b0;
            block_r   <= 1'b0;
            fire_prev <= 1'b0;
            fireReq   <= 1'b0;
            visible   <= 1'b1;
            stunned   <= 1'b0;
        end else begin
            fire_prev <= fireKey;
            fireReq   <= 1'b0;
            if (!playGame) begin
                state    <= HOLD;
                pos_x    <= POS_INIT;
                speedX   <= '0;
                cooldown <= '0;
                stun_cnt <= '0;
                pending  <= 1'b0;
                block_l  <= 1'b0;
                block_r  <= 1'b0;
                visible  <= 1'b1;
                stunned  <= 1'b0;
            end else begin
                if (startOfFrame) begin
                    block_l <= 1'b0;
                    block_r <= 1'b0;
                end
                if (startOfFrame && (state != HOLD)) begin
                    cooldown <= cd_dec;
                end
                case (state)
                    HOLD: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (playerHit) begin
                            state    <= STUNNED;
                            stunned  <= 1'b1;
                            speedX   <= '0;
                            pending  <= 1'b0;
                            stun_cnt <= STUN_INIT;
                        end else begin
                            if (!startOfFrame) begin
                                if (collision && HitEdgeCode[1]) block_r <= 1'b1;
                                if (collision && HitEdgeCode[3]) block_l <= 1'b1;
                            end else begin
                                pos_x  <= pos_new[PW-1:0];
                                speedX <= spd_new[PW-1:0];
                            end
                            // A press on the firing clk is kept for the next eligible frame.
                            if (startOfFrame && fire_ok) begin
                                fireReq  <= 1'b1;
                                pending  <= fire_rise;
                                cooldown <= COOL_INIT;
                            end else begin
                                pending <= pending | fire_rise;
                            end
                        end
                    end
                    STUNNED: begin
                        if (startOfFrame) begin
                            stun_cnt <= stun_dec;
                            if (stun_dec == '0) begin
                                state   <= RUN;
                                stunned <= 1'b0;
                                visible <= 1'b1;
                            end else begin
                                visible <= ~stun_dec[BLINK_SHIFT];
                            end
                        end
                    end
                    default: begin
                        state <= HOLD;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// Bench for player_motion_ctrl: directed frame scenarios with literal pins,
// then randomized stimulus, all checked each clk against a behavioural model.
module tb_player_motion_ctrl;

    localparam int PW       = 17;
    localparam int FL       = 4;
    localparam int INIT_X   = 240;
    localparam int FRAC     = 6;
    localparam int ACC      = 32;
    localparam int DEC      = 64;
    localparam int VMAX     = 128;
    localparam int XMIN     = 15 * 64;
    localparam int XMAX     = 562 * 64;
    localparam int COOL     = 8;
    localparam int STUNF    = 60;
    localparam int BLINK    = 2;
    localparam int S_HOLD   = 0;
    localparam int S_RUN    = 1;
    localparam int S_STUN   = 2;

    logic clk, resetN, startOfFrame, playGame, leftArrow, rightArrow, fireKey;
    logic collision, playerHit, shotBusy;
    logic [3:0] HitEdgeCode;
    logic signed [10:0] topLeftX, topLeftY;
    logic signed [PW-1:0] speedX;
    logic fireReq, visible, stunned;

    int tests = 0;
    int fails = 0;
    bit last_fire;

    int m_state, m_pos, m_spd, m_cd, m_stun;
    bit m_pend, m_bl, m_br, m_vis, m_fire, m_prev;

    player_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
        .leftArrow(leftArrow), .rightArrow(rightArrow), .fireKey(fireKey),
        .collision(collision), .HitEdgeCode(HitEdgeCode), .playerHit(playerHit),
        .shotBusy(shotBusy), .topLeftX(topLeftX), .topLeftY(topLeftY), .speedX(speedX),
        .fireReq(fireReq), .visible(visible), .stunned(stunned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_hold();
        m_state = S_HOLD; m_pos = INIT_X * 64; m_spd = 0; m_cd = 0; m_stun = 0;
        m_pend = 0; m_bl = 0; m_br = 0; m_vis = 1;
    endtask

    task automatic model_reset();
        model_hold();
        m_prev = 0; m_fire = 0;
    endtask

    // Next-state of the model from the inputs present before the coming edge.
    task automatic model_step();
        bit rise, br, bl;
        int d, s, p;
        rise   = fireKey && !m_prev;
        m_prev = fireKey;
        m_fire = 0;
        if (!playGame) begin
            model_hold();
            return;
        end
        br = m_br || (collision && HitEdgeCode[1]);
        bl = m_bl || (collision && HitEdgeCode[3]);
        if (startOfFrame && m_state != S_HOLD) m_cd = (m_cd > 0) ? m_cd - 1 : 0;
        if (startOfFrame) begin m_bl = 0; m_br = 0; end
        if (m_state == S_HOLD) begin
            m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            if (playerHit) begin
                m_state = S_STUN; m_spd = 0; m_pend = 0; m_stun = STUNF;
            end else begin
                if (!startOfFrame) begin
                    if (collision && HitEdgeCode[1]) m_br = 1;
                    if (collision && HitEdgeCode[3]) m_bl = 1;
                end else begin
                    d = (rightArrow && !leftArrow) ? 1 : ((leftArrow && !rightArrow) ? -1 : 0);
                    if (d != 0) begin
                        if ((d > 0 && br) || (d < 0 && bl)) s = 0;
                        else begin
                            s = m_spd + d * ACC;
                            if (s > VMAX) s = VMAX;
                            if (s < -VMAX) s = -VMAX;
                        end
                    end else if (m_spd > DEC) s = m_spd - DEC;
                    else if (m_spd < -DEC) s = m_spd + DEC;
                    else s = 0;
                    if ((s > 0 && br) || (s < 0 && bl)) s = 0;
                    p = m_pos + s;
                    if (p < XMIN) begin p = XMIN; s = 0; end
                    if (p > XMAX) begin p = XMAX; s = 0; end
                    m_pos = p; m_spd = s;
                    if (m_pend && m_cd == 0 && !shotBusy) begin
                        m_fire = 1; m_pend = 0; m_cd = COOL;
                    end
                end
                m_pend = m_pend || rise;
            end
        end else if (startOfFrame) begin
            m_stun = m_stun - 1;
            if (m_stun == 0) begin m_state = S_RUN; m_vis = 1; end
            else m_vis = ((m_stun >> BLINK) & 1) == 0;
        end
    endtask

    task automatic check_cycle();
        int ex;
        ex = m_pos >>> FRAC;
        tests++;
        if (topLeftX !== 11'(ex) || speedX !== PW'(m_spd) || fireReq !== m_fire ||
            visible !== m_vis || stunned !== (m_state == S_STUN) || topLeftY !== 11'(420)) begin
            fails++;
            $display("FAIL model t=%0t: dut x=%0d spd=%0d fire=%0b vis=%0b stun=%0b y=%0d | need x=%0d spd=%0d fire=%0b vis=%0b stun=%0b y=420",
                     $time, topLeftX, speedX, fireReq, visible, stunned, topLeftY,
                     ex, m_spd, m_fire, m_vis, (m_state == S_STUN));
        end
    endtask

    task automatic expect_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic run_frame(input bit coll_r, input bit hit, input bit fire_press);
        startOfFrame = 1'b1;
        step();
        last_fire = fireReq;
        startOfFrame = 1'b0;
        for (int i = 1; i < FL; i++) begin
            collision   = coll_r && (i == 1);
            HitEdgeCode = (coll_r && (i == 1)) ? 4'b0010 : 4'b0000;
            playerHit   = hit && (i == 1);
            fireKey     = fire_press && (i == 1 || i == 2);
            step();
        end
        collision = 1'b0; HitEdgeCode = 4'b0000; playerHit = 1'b0; fireKey = 1'b0;
    endtask

    initial begin
        int acc_spd[4];
        int acc_x[4];
        acc_spd = '{32, 64, 96, 128};
        acc_x   = '{240, 241, 243, 245};

        resetN = 1'b0; startOfFrame = 1'b0; playGame = 1'b0; leftArrow = 1'b0;
        rightArrow = 1'b0; fireKey = 1'b0; collision = 1'b0; HitEdgeCode = 4'b0;
        playerHit = 1'b0; shotBusy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cycle();
        expect_val("reset x", int'(topLeftX), 240);
        expect_val("reset y", int'(topLeftY), 420);
        expect_val("reset spd", int'(speedX), 0);
        expect_val("reset vis", int'(visible), 1);
        expect_val("reset stun", int'(stunned), 0);
        resetN = 1'b1;

        playGame = 1'b1;
        step();
        rightArrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_frame(0, 0, 0);
            expect_val("accel spd", int'(speedX), acc_spd[i]);
            expect_val("accel x", int'(topLeftX), acc_x[i]);
        end
        rightArrow = 1'b0;
        run_frame(0, 0, 0);
        expect_val("decel spd1", int'(speedX), 64);
        expect_val("decel x1", int'(topLeftX), 246);
        run_frame(0, 0, 0);
        expect_val("decel spd2", int'(speedX), 0);
        expect_val("decel x2", int'(topLeftX), 246);

        leftArrow = 1'b1;
        repeat (130) run_frame(0, 0, 0);
        expect_val("left clamp x", int'(topLeftX), 15);
        expect_val("left clamp spd", int'(speedX), 0);
        run_frame(0, 0, 0);
        expect_val("left hold x", int'(topLeftX), 15);
        expect_val("left hold spd", int'(speedX), 0);

        leftArrow = 1'b0; rightArrow = 1'b1;
        run_frame(1, 0, 0);
        expect_val("blk pre spd", int'(speedX), 32);
        expect_val("blk pre x", int'(topLeftX), 15);
        run_frame(0, 0, 0);
        expect_val("blk spd", int'(speedX), 0);
        expect_val("blk x", int'(topLeftX), 15);
        run_frame(0, 0, 0);
        expect_val("blk resume spd", int'(speedX), 32);
        expect_val("blk resume x", int'(topLeftX), 16);
        rightArrow = 1'b0;
        repeat (2) run_frame(0, 0, 0);

        run_frame(0, 0, 1);
        run_frame(0, 0, 0);
        expect_val("fire first", int'(last_fire), 1);
        for (int j = 1; j <= 8; j++) begin
            run_frame(0, 0, j == 2);
            expect_val("fire cooldown", int'(last_fire), (j == 8) ? 1 : 0);
        end
        for (int j = 1; j <= 12; j++) begin
            shotBusy = (j <= 10);
            run_frame(0, 0, j == 1);
            expect_val("fire busy", int'(last_fire), (j == 11) ? 1 : 0);
        end
        shotBusy = 1'b0;

        rightArrow = 1'b1;
        run_frame(0, 1, 0);
        expect_val("stun enter", int'(stunned), 1);
        expect_val("stun spd", int'(speedX), 0);
        for (int s = 1; s <= 60; s++) begin
            run_frame(0, 0, 1);
            if (s == 4) expect_val("blink f4", int'(visible), 1);
            if (s == 5) expect_val("blink f5", int'(visible), 0);
            if (s == 9) expect_val("blink f9", int'(visible), 1);
            if (s == 59) begin
                expect_val("stun f59", int'(stunned), 1);
                expect_val("stun f59 spd", int'(speedX), 0);
                expect_val("stun f59 fire", int'(last_fire), 0);
            end
        end
        expect_val("stun exit", int'(stunned), 0);
        expect_val("stun exit vis", int'(visible), 1);

        repeat (3) run_frame(0, 0, 0);
        playGame = 1'b0;
        step();
        expect_val("hold x", int'(topLeftX), 240);
        expect_val("hold spd", int'(speedX), 0);
        playGame = 1'b1;
        step();

        run_frame(0, 1, 0);
        repeat (3) run_frame(0, 0, 0);
        #2;
        resetN = 1'b0;
        model_reset();
        #1;
        check_cycle();
        expect_val("areset stun", int'(stunned), 0);
        expect_val("areset vis", int'(visible), 1);
        expect_val("areset x", int'(topLeftX), 240);
        @(posedge clk);
        #1;
        check_cycle();
        resetN = 1'b1;
        rightArrow = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            startOfFrame = ($urandom_range(0, 4) == 0);
            playGame     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) leftArrow = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rightArrow = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) fireKey = ~fireKey;
            collision    = ($urandom_range(0, 9) == 0);
            HitEdgeCode  = 4'($urandom_range(0, 15));
            playerHit    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) shotBusy = ~shotBusy;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
